stepper_move_sequencer: RTL and testbench
=========================================

Name: stepper_move_sequencer

Overview:
Upstream command source for the stepper coil-phase stage. Accepts move requests (signed relative step count plus step period) over a valid/ready handshake. Converts each request into a timed train of single-cycle 2-bit step commands that feed the coil-phase stage's command input directly. Tracks absolute position and reports busy, done and abort status to the host logic.

Parameters:
CNT_W, 16, width of signed relative step count cmd_steps
PER_W, 16, width of unsigned step period cmd_period (clock cycles per step)
POS_W, 24, width of signed absolute position counter
MIN_PERIOD, 2, smallest period honoured; smaller requests are clamped up to this value
POS_MIN, -8388608, lower soft limit (used only with STEPPER_SEQ_LIMIT_EN)
POS_MAX, 8388607, upper soft limit (used only with STEPPER_SEQ_LIMIT_EN)

Ports:
system1000  in  1  clock; all state changes on rising edge
system1000_rstn  in  1  asynchronous reset, active low
cmd_valid  in  1  move request valid
cmd_ready  out  1  sequencer can accept a request
cmd_steps  in  CNT_W  signed relative steps; sign sets direction
cmd_period  in  PER_W  cycles between steps
abort  in  1  level; terminates the current move
step_cmd  out  2  2'b00 hold, 2'b01 step forward, 2'b10 step reverse; 2'b11 never driven
busy  out  1  move in progress
done  out  1  one-cycle pulse when a move ends (normal, abort or limit)
aborted  out  1  last move ended by abort; cleared on next accept
limit_hit  out  1  last move ended at a soft limit; cleared on next accept
position  out  POS_W  signed absolute position in steps

Behaviour:
- Reset (async, system1000_rstn low): state IDLE; step_cmd=2'b00, busy=0, done=0, aborted=0, limit_hit=0, position=0, cmd_ready=1. Takes effect mid-move with no trailing step.
- All outputs registered. cmd_ready = (state==IDLE); it does not depend combinationally on cmd_valid.
- States: IDLE, RUN.
- IDLE: handshake when cmd_valid & cmd_ready at an edge.
  - Latch dir = sign(cmd_steps), remaining = |cmd_steps| (CNT_W unsigned; -2^(CNT_W-1) gives 2^(CNT_W-1)), per = max(cmd_period, MIN_PERIOD), timer = per-1.
  - Clear aborted and limit_hit.
  - If remaining==0: stay IDLE, pulse done next cycle, no step.
  - Otherwise go to RUN with busy=1.
- RUN:
  - Timer decrements each cycle.
  - When timer==0: step_cmd = dir code for exactly one cycle, remaining -= 1, position += ±1, timer reloads per-1.
  - First step appears per cycles after the accept edge. Consecutive steps are exactly per cycles apart.
  - step_cmd is 2'b00 in every non-step cycle.
- Completion: the cycle after the step that makes remaining 0, state=IDLE, busy=0, done=1 (one cycle), cmd_ready=1. A new request accepted in that cycle is legal.
- Abort: sampled only in RUN.
  - At the next edge: IDLE, done pulse, aborted=1.
  - If abort coincides with timer==0, abort wins: no step, position unchanged.
  - Abort in IDLE is ignored.
- position is two's-complement and wraps at POS_W bits when limits are disabled. position, step_cmd and remaining update at the same edge.
- cmd_steps and cmd_period are don't-care outside the handshake edge.

Optional Feature:
STEPPER_SEQ_LIMIT_EN.
- Defined: before each step, check position±1. If the result is outside [POS_MIN, POS_MAX]:
  - suppress the step (step_cmd stays 2'b00);
  - end the move as for abort, except limit_hit=1 and aborted=0.
  - A move starting at a limit toward that limit ends at its first timer expiry with no step.
  - If abort and a limit violation occur in the same cycle, abort takes priority.
- Undefined: no limit check; limit_hit is tied 0; position wraps.

Test Plan:
- Reset, then cmd_steps=3, cmd_period=4 accepted at edge 0 -> step_cmd=01 in cycles 4, 8, 12; done at 13; position=3; busy high in cycles 1-12.
- cmd_steps=-2, cmd_period=0 -> period clamped to 2; step_cmd=10 at cycles 2 and 4; position decreases by 2.
- cmd_steps=0 -> no step_cmd, done pulse next cycle, busy stays 0.
- cmd_steps=10, period=5; abort raised at cycle 15 (same cycle as 3rd step expiry) -> only 2 steps; done and aborted=1 next cycle; next accept clears aborted.
- Back-to-back: second request held valid with 2 steps -> accepted in the done cycle; first step exactly period cycles later; async reset mid-move clears all outputs immediately.
- With STEPPER_SEQ_LIMIT_EN, POS_MAX=5, position=4, cmd_steps=3 -> one step to 5, then limit_hit=1 and done, position=5.

Source files
------------

// File: rtl/stepper_move_sequencer.sv
// stepper_move_sequencer: turns signed relative move requests into timed single-cycle step commands.
// Optional soft position limits are enabled by defining STEPPER_SEQ_LIMIT_EN.
`default_nettype none

module stepper_move_sequencer #(
    parameter int CNT_W      = 16,
    parameter int PER_W      = 16,
    parameter int POS_W      = 24,
    parameter int MIN_PERIOD = 2,
    parameter int POS_MIN    = -8388608,
    parameter int POS_MAX    = 8388607
) (
    input  logic                    system1000,
    input  logic                    system1000_rstn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [CNT_W-1:0]        cmd_steps,
    input  logic [PER_W-1:0]        cmd_period,
    input  logic                    abort,
    output logic [1:0]              step_cmd,
    output logic                    busy,
    output logic                    done,
    output logic                    aborted,
    output logic                    limit_hit,
    output logic signed [POS_W-1:0] position
);

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic                    dir_q, dir_d;
    logic [CNT_W-1:0]        remaining_q, remaining_d;
    logic [PER_W-1:0]        per_q, per_d;
    logic [PER_W-1:0]        timer_q, timer_d;
    logic signed [POS_W-1:0] position_q, position_d;
    logic [1:0]              step_cmd_q, step_cmd_d;
    logic                    done_q, done_d;
    logic                    aborted_q, aborted_d;
    logic                    limit_hit_q, limit_hit_d;

    logic [CNT_W-1:0]        w_abs;
    logic [PER_W-1:0]        w_per;
    logic signed [POS_W-1:0] w_pos_step;
    logic                    w_limit_viol;

    // Magnitude is taken as unsigned, so the most negative count maps to 2^(CNT_W-1).
    assign w_abs      = cmd_steps[CNT_W-1] ? (~cmd_steps + 1'b1) : cmd_steps;
    assign w_per      = (cmd_period < PER_W'(MIN_PERIOD)) ? PER_W'(MIN_PERIOD) : cmd_period;
    assign w_pos_step = dir_q ? (position_q - 1'b1) : (position_q + 1'b1);

`ifdef STEPPER_SEQ_LIMIT_EN
    localparam logic signed [POS_W:0] C_POS_MIN = (POS_W+1)'(POS_MIN);
    localparam logic signed [POS_W:0] C_POS_MAX = (POS_W+1)'(POS_MAX);
    localparam logic signed [POS_W:0] C_ONE     = (POS_W+1)'(1);

    logic signed [POS_W:0] w_pos_sx;
    logic signed [POS_W:0] w_pos_ext;

    // One extra bit so the candidate position cannot wrap before the range test.
    assign w_pos_sx     = {position_q[POS_W-1], position_q};
    assign w_pos_ext    = dir_q ? (w_pos_sx - C_ONE) : (w_pos_sx + C_ONE);
    assign w_limit_viol = (w_pos_ext < C_POS_MIN) || (w_pos_ext > C_POS_MAX);
`else
    logic unused_limits;
    assign unused_limits = (POS_MIN > POS_MAX);
    assign w_limit_viol  = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        remaining_d = remaining_q;
        per_d       = per_q;
        timer_d     = timer_q;
        position_d  = position_q;
        step_cmd_d  = 2'b00;
        done_d      = 1'b0;
        aborted_d   = aborted_q;
        limit_hit_d = limit_hit_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    dir_d       = cmd_steps[CNT_W-1];
                    remaining_d = w_abs;
                    per_d       = w_per;
                    timer_d     = w_per - 1'b1;
                    aborted_d   = 1'b0;
                    limit_hit_d = 1'b0;
                    if (w_abs == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                timer_d = (timer_q == '0) ? (per_q - 1'b1) : (timer_q - 1'b1);
                if (remaining_q == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (abort) begin
                    state_d   = S_IDLE;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                end else if (timer_q == PER_W'(1)) begin
                    // The step is registered together with the timer reaching zero.
                    if (w_limit_viol) begin
                        state_d     = S_IDLE;
                        done_d      = 1'b1;
                        limit_hit_d = 1'b1;
                    end else begin
                        step_cmd_d  = dir_q ? 2'b10 : 2'b01;
                        remaining_d = remaining_q - 1'b1;
                        position_d  = w_pos_step;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            state_q     <= S_IDLE;
            dir_q       <= 1'b0;
            remaining_q <= '0;
            per_q       <= '0;
            timer_q     <= '0;
            position_q  <= '0;
            step_cmd_q  <= 2'b00;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            limit_hit_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            remaining_q <= remaining_d;
            per_q       <= per_d;
            timer_q     <= timer_d;
            position_q  <= position_d;
            step_cmd_q  <= step_cmd_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
            limit_hit_q <= limit_hit_d;
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q == S_RUN);
    assign step_cmd  = step_cmd_q;
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign limit_hit = limit_hit_q;
    assign position  = position_q;

endmodule

`default_nettype wire

// File: tb/tb_stepper_move_sequencer.sv
// Directed bench for stepper_move_sequencer: table of moves plus abort, back-to-back, reset and limit sequences.
`timescale 1ns/1ps
`default_nettype none

module tb_stepper_move_sequencer;

    localparam int CNT_W = 16;
    localparam int PER_W = 16;
    localparam int POS_W = 24;
`ifdef STEPPER_SEQ_LIMIT_EN
    localparam int TB_POS_MAX = 5;
`else
    localparam int TB_POS_MAX = 8388607;
`endif

    logic                    clk = 1'b0;
    logic                    rstn = 1'b0;
    logic                    cmd_valid = 1'b0;
    logic                    abort = 1'b0;
    logic [CNT_W-1:0]        cmd_steps = '0;
    logic [PER_W-1:0]        cmd_period = '0;
    logic                    cmd_ready;
    logic [1:0]              step_cmd;
    logic                    busy, done, aborted, limit_hit;
    logic signed [POS_W-1:0] position;

    stepper_move_sequencer #(
        .CNT_W(CNT_W), .PER_W(PER_W), .POS_W(POS_W), .MIN_PERIOD(2),
        .POS_MIN(-8388608), .POS_MAX(TB_POS_MAX)
    ) dut (
        .system1000      (clk),
        .system1000_rstn (rstn),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_steps       (cmd_steps),
        .cmd_period      (cmd_period),
        .abort           (abort),
        .step_cmd        (step_cmd),
        .busy            (busy),
        .done            (done),
        .aborted         (aborted),
        .limit_hit       (limit_hit),
        .position        (position)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         steps;
        int         period;
        logic [1:0] code;
        int         nsteps;
        int         per;
        int         pos_after;
    } vec_t;

    vec_t tbl[5];

    // Status vector order: {cmd_ready, busy, done, aborted, limit_hit, step_cmd[1:0]}
    function automatic logic [6:0] st(input logic r, input logic b, input logic d,
                                      input logic a, input logic l, input logic [1:0] s);
        return {r, b, d, a, l, s};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_status(input string name, input logic [6:0] exp);
        chk(name, {25'd0, cmd_ready, busy, done, aborted, limit_hit, step_cmd}, {25'd0, exp});
    endtask

    task automatic chk_pos(input string name, input int exp);
        logic [POS_W-1:0] e;
        e = POS_W'(exp);
        chk(name, {8'd0, position}, {8'd0, e});
    endtask

    task automatic accept(input int steps, input int period);
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_steps  = CNT_W'(steps);
        cmd_period = PER_W'(period);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic run_move(input vec_t v, input int idx);
        int         total;
        logic [1:0] es;
        logic       eb;
        total = v.nsteps * v.per;
        accept(v.steps, v.period);
        for (int n = 1; n <= total + 2; n++) begin
            @(negedge clk);
            es = (n <= total && (n % v.per) == 0) ? v.code : 2'b00;
            eb = (n <= total);
            chk_status($sformatf("vec%0d c%0d", idx, n), st(!eb, eb, n == total + 1, 1'b0, 1'b0, es));
        end
        chk_pos($sformatf("vec%0d pos", idx), v.pos_after);
    endtask

    initial begin
        tbl[0] = '{steps:  3, period: 4, code: 2'b01, nsteps: 3, per: 4, pos_after: 3};
        tbl[1] = '{steps: -2, period: 0, code: 2'b10, nsteps: 2, per: 2, pos_after: 1};
        tbl[2] = '{steps:  0, period: 7, code: 2'b00, nsteps: 0, per: 7, pos_after: 1};
        tbl[3] = '{steps:  1, period: 1, code: 2'b01, nsteps: 1, per: 2, pos_after: 2};
        tbl[4] = '{steps: -1, period: 3, code: 2'b10, nsteps: 1, per: 3, pos_after: 1};

        #12;
        chk_status("reset status", st(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00));
        chk_pos("reset pos", 0);
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 5; i++) run_move(tbl[i], i);

        // Abort on the edge that would issue the third step: only two steps land.
        accept(10, 5);
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            chk_status($sformatf("abort c%0d", n),
                       st(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, (n % 5 == 0) ? 2'b01 : 2'b00));
            if (n == 14) abort = 1'b1;
        end
        @(negedge clk);
        chk_status("abort end", st(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00));
        chk_pos("abort pos", 3);
        @(negedge clk);
        chk_status("abort idle ignored", st(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00));
        abort = 1'b0;

        accept(0, 3);
        @(negedge clk);
        chk_status("accept clears aborted", st(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00));

        // Back-to-back: second request held valid until the done cycle of the first.
        accept(-1, 3);
        cmd_valid  = 1'b1;
        cmd_steps  = CNT_W'(-1);
        cmd_period = PER_W'(4);
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            chk_status($sformatf("b2b first c%0d", n),
                       st(n == 4, n <= 3, n == 4, 1'b0, 1'b0, (n == 3) ? 2'b10 : 2'b00));
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            chk_status($sformatf("b2b second c%0d", n),
                       st(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, (n == 4) ? 2'b10 : 2'b00));
        end
        chk_pos("b2b pos", 1);

        // Asynchronous reset while a step is on the output.
        #1 rstn = 1'b0;
        #1;
        chk_status("async reset status", st(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00));
        chk_pos("async reset pos", 0);
        #2 rstn = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            chk_status($sformatf("post reset c%0d", n), st(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00));
        end
        chk_pos("post reset pos", 0);

`ifdef STEPPER_SEQ_LIMIT_EN
        accept(4, 2);
        repeat (9) @(negedge clk);
        chk_pos("limit pre pos", 4);
        accept(3, 2);
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            if (n < 4)
                chk_status($sformatf("limit c%0d", n),
                           st(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, (n == 2) ? 2'b01 : 2'b00));
            else
                chk_status("limit end", st(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00));
        end
        chk_pos("limit pos", 5);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
